// File: rtl/irq_perturbation_gen.sv
// -----------------------------------------------------------------------------
// irq_perturbation_gen
//
// Interrupt-stimulus stage of the testbench perturbation module. It turns a
// 32-bit perturbation mode code into single interrupt requests, with an ID,
// towards the core. Each request is held until the core acknowledges it with
// the matching ID.
//
// Mode codes: 1 STANDARD (never triggers), 2 RANDOM (LFSR driven),
//             3 PC_TRIG (PC match), 4 SOFTWARE_DEFINED (sw pulse).
//             Any other code behaves as STANDARD.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   mode_i              perturbation mode code, sampled only while idle
//   delay_i             trigger-to-request delay for PC_TRIG / SOFTWARE_DEFINED
//   pc_i, pc_valid_i    core ID-stage PC and its valid strobe
//   pc_trig_i           trigger PC, pc_trig_id_i ID issued on a PC match
//   sw_irq_req_i        one-cycle software trigger, sw_irq_id_i its ID
//   irq_ack_i           core acknowledge, irq_ack_id_i acknowledged ID
//   irq_o, irq_id_o     interrupt request and its ID
//   busy_o              high whenever a request is being delayed/held/released
//   ack_err_o           sticky flag: an acknowledge carried the wrong ID
//
// Optional build macro IRQ_PERTURBATION_STATS_EN adds:
//   irq_count_o [31:0]  number of correctly acknowledged interrupts (wraps)
//   max_lat_o   [15:0]  largest request-to-ack cycle count (saturates)
// -----------------------------------------------------------------------------
module irq_perturbation_gen #(
    parameter int          NUM_IRQ      = 32,
    parameter int          IRQ_ID_WIDTH = $clog2(NUM_IRQ),
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             mode_i,
    input  logic [7:0]              delay_i,
    input  logic [31:0]             pc_i,
    input  logic                    pc_valid_i,
    input  logic [31:0]             pc_trig_i,
    input  logic [IRQ_ID_WIDTH-1:0] pc_trig_id_i,
    input  logic                    sw_irq_req_i,
    input  logic [IRQ_ID_WIDTH-1:0] sw_irq_id_i,
    input  logic                    irq_ack_i,
    input  logic [IRQ_ID_WIDTH-1:0] irq_ack_id_i,
    output logic                    irq_o,
    output logic [IRQ_ID_WIDTH-1:0] irq_id_o,
    output logic                    busy_o,
    output logic                    ack_err_o
`ifdef IRQ_PERTURBATION_STATS_EN
    ,
    output logic [31:0]             irq_count_o,
    output logic [15:0]             max_lat_o
`endif
);

    localparam logic [31:0] MODE_RANDOM  = 32'd2;
    localparam logic [31:0] MODE_PC_TRIG = 32'd3;
    localparam logic [31:0] MODE_SW      = 32'd4;

    typedef enum logic [1:0] {IDLE, DELAY, REQ, HOLDOFF} state_t;

    state_t                  state;
    logic [15:0]             lfsr;
    logic                    lfsr_fb;
    logic [7:0]              dly_cnt;
    logic [IRQ_ID_WIDTH-1:0] pend_id;

    logic                    trig;
    logic [IRQ_ID_WIDTH-1:0] trig_id;
    logic [7:0]              trig_dly;
    logic                    ack_ok;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign ack_ok = (state == REQ) && irq_ack_i && (irq_ack_id_i == pend_id);

    // Trigger source selection; only consulted while idle.
    always_comb begin
        trig     = 1'b0;
        trig_id  = '0;
        trig_dly = '0;
        case (mode_i)
            MODE_RANDOM: begin
                trig     = (lfsr[3:0] == 4'd0);
                trig_id  = lfsr[IRQ_ID_WIDTH+3:4];
                trig_dly = {4'd0, lfsr[15:12]};
            end
            MODE_PC_TRIG: begin
                trig     = pc_valid_i && (pc_i == pc_trig_i);
                trig_id  = pc_trig_id_i;
                trig_dly = delay_i;
            end
            MODE_SW: begin
                trig     = sw_irq_req_i;
                trig_id  = sw_irq_id_i;
                trig_dly = delay_i;
            end
            default: ;
        endcase
    end

    // Request FSM with registered outputs. irq_o rises on the edge that enters
    // REQ, so a delay of d gives d+1 cycles from trigger to request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            dly_cnt   <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            busy_o    <= 1'b0;
            ack_err_o <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                IDLE: begin
                    if (trig) begin
                        pend_id <= trig_id;
                        busy_o  <= 1'b1;
                        if (trig_dly == 8'd0) begin
                            state    <= REQ;
                            irq_o    <= 1'b1;
                            irq_id_o <= trig_id;
                        end else begin
                            state   <= DELAY;
                            dly_cnt <= trig_dly;
                        end
                    end
                end
                DELAY: begin
                    dly_cnt <= dly_cnt - 8'd1;
                    if (dly_cnt == 8'd1) begin
                        state    <= REQ;
                        irq_o    <= 1'b1;
                        irq_id_o <= pend_id;
                    end
                end
                REQ: begin
                    if (ack_ok) begin
                        state <= HOLDOFF;
                        irq_o <= 1'b0;
                    end else if (irq_ack_i) begin
                        ack_err_o <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    // guaranteed low cycle between consecutive requests
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IRQ_PERTURBATION_STATS_EN
    logic [15:0] lat_cnt;
    logic [15:0] lat_now;

    // latency including the current REQ cycle, saturating
    assign lat_now = (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_count_o <= '0;
            max_lat_o   <= '0;
            lat_cnt     <= '0;
        end else if (state == REQ) begin
            if (ack_ok) begin
                irq_count_o <= irq_count_o + 32'd1;
                lat_cnt     <= '0;
                if (lat_now > max_lat_o) begin
                    max_lat_o <= lat_now;
                end
            end else begin
                lat_cnt <= lat_now;
            end
        end else begin
            lat_cnt <= '0;
        end
    end
`endif

endmodule

// File: doc/irq_perturbation_gen.md
Name: irq_perturbation_gen

Overview:
- Interrupt-stimulus stage of the example testbench perturbation module. It sits between the perturbation mode selection and the core's interrupt inputs.
- Consumes the 32-bit perturbation mode code (STANDARD=1, RANDOM=2, PC_TRIG=3, SOFTWARE_DEFINED=4) and produces one interrupt request at a time, with an ID, to the core.
- Holds each request until the core acknowledges it with the matching ID.

Parameters:
- NUM_IRQ, 32, number of interrupt lines; must be a power of 2.
- IRQ_ID_WIDTH, $clog2(NUM_IRQ), ID width.
- LFSR_SEED, 16'hACE1, reset value of the random generator; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- mode_i  in  32  perturbation mode code.
- delay_i  in  8  cycles from trigger to request, for PC_TRIG and SOFTWARE_DEFINED.
- pc_i  in  32  core ID-stage PC.
- pc_valid_i  in  1  pc_i valid this cycle.
- pc_trig_i  in  32  trigger PC for PC_TRIG.
- pc_trig_id_i  in  IRQ_ID_WIDTH  ID issued on a PC trigger.
- sw_irq_req_i  in  1  one-cycle software trigger pulse.
- sw_irq_id_i  in  IRQ_ID_WIDTH  ID for the software trigger.
- irq_ack_i  in  1  core acknowledges an interrupt.
- irq_ack_id_i  in  IRQ_ID_WIDTH  acknowledged ID.
- irq_o  out  1  request.
- irq_id_o  out  IRQ_ID_WIDTH  requested ID.
- busy_o  out  1  FSM not in IDLE.
- ack_err_o  out  1  sticky ack-ID-mismatch flag.

Behaviour:
- Reset: one clock cycle, synchronous.
  - Forces state to IDLE, lfsr to LFSR_SEED, delay counter to 0.
  - All outputs go to 0: irq_o=0, irq_id_o=0, busy_o=0, ack_err_o=0.
  - Reset asserted mid-request drops irq_o on the next edge; no ack is expected afterwards.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left every cycle that is not in reset, in every mode.
  - New bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
- FSM states: IDLE, DELAY, REQ, HOLDOFF. Mode is sampled only in IDLE. Any mode code other than 2/3/4 behaves as STANDARD.
- IDLE, by mode:
  - STANDARD: stays in IDLE and never triggers.
  - RANDOM: triggers when lfsr[3:0]==0.
    - pend_id = lfsr[IRQ_ID_WIDTH+3:4].
    - Delay count = lfsr[15:12].
  - PC_TRIG: triggers when pc_valid_i && pc_i==pc_trig_i.
    - pend_id = pc_trig_id_i.
    - Delay count = delay_i.
  - SOFTWARE_DEFINED: triggers on sw_irq_req_i.
    - pend_id = sw_irq_id_i.
    - Delay count = delay_i.
    - An sw_irq_req_i pulse arriving outside IDLE is dropped (no queue).
- Leaving IDLE on a trigger: delay count 0 goes directly to REQ; otherwise the FSM goes to DELAY with count loaded.
- DELAY: decrement each cycle; move to REQ on the cycle the count reaches 1. Total trigger-to-irq_o latency is delay+1 cycles; for delay 0 it is 1 cycle.
- REQ: irq_o=1 and irq_id_o=pend_id, both stable until acknowledged.
  - irq_ack_i with irq_ack_id_i==pend_id: go to HOLDOFF; irq_o drops on the next edge.
  - irq_ack_i with a mismatched ID: set ack_err_o (sticky until reset) and stay in REQ.
- HOLDOFF: exactly 1 cycle with irq_o=0, then IDLE. This guarantees at least one low cycle between requests.
- irq_id_o retains its last value while irq_o=0.
- busy_o=1 in every state except IDLE.
- A mode change while busy takes effect at the next IDLE.

Optional Feature:
- Macro: IRQ_PERTURBATION_STATS_EN.
- When defined:
  - Adds output irq_count_o [31:0]: number of correctly acknowledged interrupts; reset 0; wraps 0xFFFFFFFF to 0.
  - Adds output max_lat_o [15:0]: largest REQ-to-ack cycle count seen; saturates at 0xFFFF.
- When not defined: neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Reset, then mode=1 for 1000 cycles -> irq_o and busy_o stay 0, ack_err_o=0.
- mode=4, delay_i=3, one pulse on sw_irq_req_i with sw_irq_id_i=7 -> irq_o=1 with irq_id_o=7 exactly 4 cycles after the pulse; ack with ID 7 -> irq_o=0 next cycle, busy_o=0 two cycles after the ack.
- mode=3, pc_trig_i=0x80, pc_trig_id_i=11, delay_i=0, pc_i=0x80 with pc_valid_i=1 -> irq_o=1 with ID 11 the next cycle; the same PC with pc_valid_i=0 -> no request.
- In REQ with ID 5, ack with ID 6 -> ack_err_o=1 and irq_o stays 1; then ack with ID 5 -> release, and ack_err_o stays 1.
- mode=2 from reset with the default seed -> the first trigger occurs on the first cycle where lfsr[3:0]==0; irq_id_o and the delay match a reference LFSR model, and no two requests occur without a low cycle between them.
- rst_i asserted for one cycle while in REQ -> all outputs 0 the next cycle and lfsr back to 0xACE1; an sw_irq_req_i pulse during DELAY is ignored.
